// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port, combinational-read data memory.
// Optional out-of-range checking is compiled in with `define DMEM_BOUNDS_CHECK_EN.
module dmem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic [DATA_W-1:0] rdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic [DATA_W-1:0] rdata1,
  output logic              ack1,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
`ifdef DMEM_BOUNDS_CHECK_EN
  ,
  output logic              err
`endif
);

`ifdef DMEM_BOUNDS_CHECK_EN
  localparam bit BoundsEn = 1'b1;
`else
  localparam bit BoundsEn = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state_q;
  logic              last_q;
  logic              sel_q;
  logic              wr_q;
  logic              oob_q;
  logic [ADDR_W-1:0] mem_a_q;
  logic              mem_we_q;
  logic [DATA_W-1:0] mem_wd_q;
  logic              ack0_q, ack1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
`ifdef DMEM_BOUNDS_CHECK_EN
  logic              err_q;
`endif

  logic              win_d;
  logic              win_we_d;
  logic              win_oob_d;
  logic [ADDR_W-1:0] win_addr_d;
  logic [DATA_W-1:0] win_wd_d;
  logic [DATA_W-1:0] rd_val_d;

  // On a tie the port that did not win last time goes first.
  always_comb begin
    win_d = req1;
    if (req0 && req1) win_d = ~last_q;
  end

  assign win_we_d   = win_d ? we1    : we0;
  assign win_addr_d = win_d ? addr1  : addr0;
  assign win_wd_d   = win_d ? wdata1 : wdata0;
  assign win_oob_d  = BoundsEn && (win_addr_d >= ADDR_W'(DEPTH));
  assign rd_val_d   = oob_q ? '0 : mem_rd;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      sel_q    <= 1'b0;
      wr_q     <= 1'b0;
      oob_q    <= 1'b0;
      mem_a_q  <= '0;
      mem_we_q <= 1'b0;
      mem_wd_q <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifdef DMEM_BOUNDS_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            sel_q    <= win_d;
            last_q   <= win_d;
            wr_q     <= win_we_d;
            oob_q    <= win_oob_d;
            mem_a_q  <= win_addr_d;
            mem_we_q <= win_we_d && !win_oob_d;
            mem_wd_q <= win_wd_d;
            state_q  <= ACCESS;
          end else begin
            mem_we_q <= 1'b0;
          end
        end
        ACCESS: begin
          // Memory read data is captured before the write (if any) lands.
          if (!wr_q || oob_q) begin
            if (sel_q) rdata1_q <= rd_val_d;
            else       rdata0_q <= rd_val_d;
          end
          if (sel_q) ack1_q <= 1'b1;
          else       ack0_q <= 1'b1;
          mem_we_q <= 1'b0;
`ifdef DMEM_BOUNDS_CHECK_EN
          err_q    <= oob_q;
`endif
          state_q  <= DONE;
        end
        DONE: begin
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
`ifdef DMEM_BOUNDS_CHECK_EN
          err_q   <= 1'b0;
`endif
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_a  = mem_a_q;
  assign mem_we = mem_we_q;
  assign mem_wd = mem_wd_q;
  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;
`ifdef DMEM_BOUNDS_CHECK_EN
  assign err    = err_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: hand-derived vector table, directed corner sequences and
// random traffic checked against a transaction-level model of arbitration and memory.
module tb_dmem_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;
`ifdef DMEM_BOUNDS_CHECK_EN
  localparam bit BCHK = 1'b1;
`else
  localparam bit BCHK = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0, mem_a;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0, rdata0, rdata1, mem_wd, mem_rd;
  logic ack0, ack1, mem_we;
`ifdef DMEM_BOUNDS_CHECK_EN
  logic err;
`endif

  logic [DW-1:0] mem [32];
  always #5 clk = ~clk;
  assign mem_rd = mem[mem_a[4:0]];
  always @(posedge clk) if (mem_we) mem[mem_a[4:0]] <= mem_wd;

  dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .rdata0(rdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .rdata1(rdata1), .ack1(ack1),
    .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
`ifdef DMEM_BOUNDS_CHECK_EN
    , .err(err)
`endif
  );

  // Reference model: memory image, round-robin history and each port's last read data.
  logic [DW-1:0] m_mem [32];
  bit            m_last;
  logic [DW-1:0] m_rd [2];
  int checks = 0, errors = 0;

  typedef struct {
    bit r0; bit w0; logic [31:0] a0; logic [31:0] d0;
    bit r1; bit w1; logic [31:0] a1; logic [31:0] d1;
    int first; logic [31:0] rd0; logic [31:0] rd1;
  } vec_t;
  vec_t vecs [9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_last = 1'b1;
    m_rd[0] = '0;
    m_rd[1] = '0;
  endtask

  // Serve one transaction from IDLE; ap returns the port the DUT actually acked.
  task automatic serve(input string nm, input bit keep, output int ap);
    int p, lat;
    bit w, oob, seen;
    logic [31:0] a, d;
    ap = -1;
    p = (req0 && req1) ? (m_last ? 0 : 1) : (req0 ? 0 : 1);
    w = p ? we1 : we0;
    a = p ? addr1 : addr0;
    d = p ? wdata1 : wdata0;
    oob = BCHK && (a >= 32);
    seen = 1'b0;
    lat = 0;
    for (int i = 1; i <= 6 && !seen; i++) begin
      tick();
      if (i == 1) begin
        chk({nm, " mem_a"}, mem_a, a);
        chk({nm, " mem_we"}, mem_we, w && !oob);
      end
      if (ack0 || ack1) begin
        seen = 1'b1;
        lat = i;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: no ack within 6 cycles", nm);
      return;
    end
    ap = ack1 ? 1 : 0;
    m_last = p[0];
    if (oob) m_rd[p] = '0;
    else if (!w) m_rd[p] = m_mem[a[4:0]];
    else m_mem[a[4:0]] = d;
    chk({nm, " latency"}, lat, 2);
    chk({nm, " ack"}, {ack1, ack0}, p ? 2'b10 : 2'b01);
    chk({nm, " rdata0"}, rdata0, m_rd[0]);
    chk({nm, " rdata1"}, rdata1, m_rd[1]);
`ifdef DMEM_BOUNDS_CHECK_EN
    chk({nm, " err"}, err, oob);
`endif
    if (!keep) begin
      if (p == 1) req1 = 1'b0;
      else req0 = 1'b0;
    end
    tick();
    chk({nm, " ack pulse"}, {ack1, ack0, mem_we}, 3'b000);
`ifdef DMEM_BOUNDS_CHECK_EN
    chk({nm, " err clear"}, err, 1'b0);
`endif
  endtask

  task automatic set_ports(input bit r0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                           input bit r1, input bit w1, input logic [31:0] a1, input logic [31:0] d1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ap, ap2;
    int alt [4];
    alt = '{0, 1, 0, 1};
    for (int i = 0; i < 32; i++) begin
      mem[i] = '0;
      m_mem[i] = '0;
    end
    model_reset();

    vecs[0] = '{1,1,5,32'hDEADBEEF, 0,0,0,0, 0, 32'h0,        32'h0};
    vecs[1] = '{1,0,5,0,             0,0,0,0, 0, 32'hDEADBEEF, 32'h0};
    vecs[2] = '{0,0,0,0,             1,1,2,32'h22, 1, 32'hDEADBEEF, 32'h0};
    vecs[3] = '{1,0,1,0,             1,0,2,0, 0, 32'h0,        32'h22};
    vecs[4] = '{1,1,7,32'h77,        1,0,7,0, 0, 32'h0,        32'h77};
    vecs[5] = '{0,0,0,0,             1,1,1,32'h11, 1, 32'h0,   32'h77};
    vecs[6] = '{1,0,1,0,             1,0,5,0, 0, 32'h11,       32'hDEADBEEF};
    vecs[7] = '{1,0,2,0,             0,0,0,0, 0, 32'h22,       32'hDEADBEEF};
    vecs[8] = '{1,0,7,0,             1,0,1,0, 1, 32'h77,       32'h11};

    // Reset then idle
    rst_n = 1'b0;
    tick(); tick();
    chk("reset outputs", {ack0, ack1, mem_we, mem_a, mem_wd, rdata0, rdata1}, '0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle outputs", {ack0, ack1, mem_we, rdata0, rdata1}, '0);
    end

    // Vector table
    for (int v = 0; v < 9; v++) begin
      set_ports(vecs[v].r0, vecs[v].w0, vecs[v].a0, vecs[v].d0,
                vecs[v].r1, vecs[v].w1, vecs[v].a1, vecs[v].d1);
      serve($sformatf("vec%0d", v), 1'b0, ap);
      chk($sformatf("vec%0d first", v), ap, vecs[v].first);
      if (req0 || req1) serve($sformatf("vec%0d second", v), 1'b0, ap2);
      chk($sformatf("vec%0d rd0", v), rdata0, vecs[v].rd0);
      chk($sformatf("vec%0d rd1", v), rdata1, vecs[v].rd1);
    end

    // Both held high after reset: grants alternate 0,1,0,1
    rst_n = 1'b0;
    set_ports(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    model_reset();
    set_ports(1, 0, 3, 0, 1, 0, 4, 0);
    for (int k = 0; k < 4; k++) begin
      serve($sformatf("alt%0d", k), 1'b1, ap);
      chk($sformatf("alt%0d port", k), ap, alt[k]);
    end
    serve("alt drain0", 1'b0, ap);
    serve("alt drain1", 1'b0, ap);

    // Loader burst on port 1, then port 0 reads one word back
    for (int i = 0; i < 8; i++) begin
      set_ports(0, 0, 0, 0, 1, 1, i, 32'h100 + i);
      serve($sformatf("load%0d", i), 1'b0, ap);
      chk($sformatf("load%0d port", i), ap, 1);
    end
    set_ports(1, 0, 3, 0, 0, 0, 0, 0);
    serve("readback", 1'b0, ap);
    chk("readback data", rdata0, 32'h103);

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      int pat;
      pat = $urandom_range(1, 3);
      set_ports(pat[0], $urandom_range(0, 1), $urandom_range(0, 31), $urandom,
                pat[1], $urandom_range(0, 1), $urandom_range(0, 31), $urandom);
      serve($sformatf("rnd%0d", n), 1'b0, ap);
      if (req0 || req1) serve($sformatf("rnd%0d b", n), 1'b0, ap2);
    end

    // Reset during ACCESS of a port 0 read
    set_ports(1, 0, 5, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b0;
    tick();
    chk("midreset outputs", {ack0, ack1, mem_we, mem_a, mem_wd, rdata0, rdata1}, '0);
    req0 = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    set_ports(1, 0, 2, 0, 1, 0, 3, 0);
    serve("post reset tie", 1'b0, ap);
    chk("post reset winner", ap, 0);
    serve("post reset tie b", 1'b0, ap2);

`ifdef DMEM_BOUNDS_CHECK_EN
    set_ports(1, 1, 40, 32'h55, 0, 0, 0, 0);
    serve("oob write", 1'b0, ap);
    chk("oob rdata0", rdata0, 32'h0);
    chk("oob no write", mem[8], m_mem[8]);
`else
    set_ports(1, 0, 40, 0, 0, 0, 0, 0);
    serve("addr 40 passthrough", 1'b0, ap);
    chk("addr 40 port", ap, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbitrates the single-port, 32-word data memory between two requesters: port 0 (processor load/store path) and port 1 (loader/debug port).
- Sits between the requesters and the data memory: drives its address, write-enable and write-data inputs, and samples its combinational read-data output.
- Runs a 3-state sequencer with round-robin fairness and a one-cycle ack pulse per transaction.

Parameters:
- DATA_W, 32, data width of write data, read data and the memory data bus.
- ADDR_W, 32, address width of the requester and memory address buses (word address).
- DEPTH, 32, number of valid memory words; used only when the optional feature is compiled in.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- req0  input  1  port 0 request; held high until ack0.
- we0  input  1  port 0 write (1) / read (0); stable while req0 is high.
- addr0  input  ADDR_W  port 0 word address; stable while req0 is high.
- wdata0  input  DATA_W  port 0 write data; stable while req0 is high.
- rdata0  output  DATA_W  port 0 read data; valid while ack0 is high.
- ack0  output  1  port 0 completion, one-cycle pulse.
- req1, we1, addr1, wdata1, rdata1, ack1: same as port 0, for port 1.
- mem_a  output  ADDR_W  memory address.
- mem_we  output  1  memory write enable.
- mem_wd  output  DATA_W  memory write data.
- mem_rd  input  DATA_W  memory read data (combinational from mem_a).
- err  output  1  out-of-range flag; present only with DMEM_BOUNDS_CHECK_EN.

Behaviour:
- Reset: when rst_n is low at a clk edge:
  - state=IDLE; ack0=ack1=0; rdata0=rdata1=0; mem_we=0; mem_a=0; mem_wd=0; err=0.
  - last_grant=1, so port 0 wins the first tie.
- Registered outputs: mem_a, mem_we, mem_wd and the ack/rdata outputs are all registered.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - No request: stay in IDLE; mem_we=0.
  - Exactly one req high: grant that port.
  - Both req high: grant the port != last_grant.
  - On grant: latch addr/we/wdata into mem_a/mem_we/mem_wd, set sel=winner, last_grant=winner, go to ACCESS.
- ACCESS (one cycle):
  - The memory sees the registered command. A write commits at the closing edge.
  - At the closing edge: rdata[sel] <= mem_rd (reads only; writes leave rdata unchanged), ack[sel] <= 1, mem_we <= 0, go to DONE.
- DONE (one cycle):
  - ack[sel] is high; req inputs are ignored.
  - Requester must drop req during DONE or later.
  - Next edge: ack cleared, go to IDLE.
- Latency and throughput:
  - Request seen in IDLE at edge N → ack high in cycle N+2..N+3.
  - Maximum throughput is one access per 3 cycles.
- Read data: rdata reflects memory contents before any write in the same transaction.
- Held requests: a req still high in IDLE after its DONE is a new request. Round-robin then favours the other port if it is also requesting.
- Losing requester: waits at most one transaction.
- Reset mid-transaction: abort immediately to the reset values. If reset coincides with the ACCESS closing edge, the write may or may not commit. The requester must re-issue.
- req0/req1 changing while not acked: undefined; the bench must not do this.
- Address handling: no truncation; mem_a carries the full ADDR_W address.

Optional Feature:
- DMEM_BOUNDS_CHECK_EN, defined:
  - In IDLE, if the winner's address >= DEPTH: mem_we forced to 0 for that transaction, err=1 during DONE, rdata[sel]=0.
  - ack still pulses normally; err clears on leaving DONE.
- DMEM_BOUNDS_CHECK_EN, undefined:
  - No err port and no check; all addresses are passed through.

Test Plan:
1. Reset then idle: rst_n=0 for 2 cycles, then 1 with no req → all outputs 0, state IDLE, mem_we never asserted.
2. Port 0 write then read:
   - req0, we0=1, addr0=5, wdata0=0xDEADBEEF → ack0 pulses at N+2.
   - Then req0, we0=0, addr0=5 → rdata0=0xDEADBEEF with ack0.
3. Simultaneous requests: both req high, addr0=1, addr1=2 (reads) → port 0 acked first, then port 1. With both held high, grants alternate 0,1,0,1 over 4 transactions.
4. Port 1 loader: 8 writes, addr1=0..7, data=0x100+i, then port 0 reads addr 3 → rdata0=0x103. ack1 exactly once per write; no ack0 during port 1 transactions.
5. Reset mid-operation: assert rst_n=0 during ACCESS of a port 0 read → no ack0; outputs return to reset values. A subsequent simultaneous request is granted to port 0.
6. Bounds check (DMEM_BOUNDS_CHECK_EN defined): port 0 write addr0=40, wdata0=0x55 → mem_we stays 0, err=1 with ack0, rdata0=0. A read of addr 40 with the macro undefined passes mem_a=40 unchanged.
